// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared constants for the sysid checker: FSM encoding, slave word map, stall counter width.
package first_nios2_system_sysid_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_ID  = 2'd1,
      RD_TS  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic ADDR_ID     = 1'b0;
   localparam logic ADDR_TS     = 1'b1;
   localparam int   STALL_CNT_W = 16;

endpackage

// File: rtl/first_nios2_system_sysid_wdog.sv
// Saturating stall counter; flags expiry on the stall cycle that brings the count up to limit.
module first_nios2_system_sysid_wdog
   import first_nios2_system_sysid_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   enable,
   input  logic [STALL_CNT_W-1:0] limit,
   output logic                   expired
);

   logic [STALL_CNT_W-1:0] r_cnt;
   logic [STALL_CNT_W-1:0] w_limit_m1;

   assign w_limit_m1 = limit - 1'b1;

   // expired fires on the limit-th stall so read is never held beyond limit stalls
   assign expired = enable && (r_cnt >= w_limit_m1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (clear)
         r_cnt <= '0;
      else if (enable && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them against the build values.
module first_nios2_system_sysid_checker
   import first_nios2_system_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd7,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1384977422,
   parameter int          TIMEOUT_CYCLES     = 255
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [STALL_CNT_W-1:0] LIMIT = TIMEOUT_CYCLES[STALL_CNT_W-1:0];

   state_t      r_state, w_next;
   logic        w_start, w_accept, w_stall, w_expired;
   logic        r_id_ok, r_ts_ok, r_timeout;
   logic [31:0] r_id_value, r_ts_value;

   assign w_start  = (r_state == IDLE) && start;
   assign w_accept = read && !waitrequest;
   assign w_stall  = read && waitrequest;

   first_nios2_system_sysid_wdog u_wdog (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (w_start || w_accept),
      .enable  (w_stall),
      .limit   (LIMIT),
      .expired (w_expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      read    = 1'b0;
      address = ADDR_ID;
      busy    = 1'b1;
      done    = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_next = RD_ID;
         end
         RD_ID: begin
            read    = 1'b1;
            address = ADDR_ID;
            if (!waitrequest)  w_next = RD_TS;
            else if (w_expired) w_next = FINISH;
         end
         RD_TS: begin
            read    = 1'b1;
            address = ADDR_TS;
            if (!waitrequest)  w_next = FINISH;
            else if (w_expired) w_next = FINISH;
         end
         FINISH: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Values are cleared at start so an aborted or unread word reads back as zero
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= '0;
         r_ts_value <= '0;
      end else if (w_start) begin
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= '0;
         r_ts_value <= '0;
      end else if (w_accept) begin
         if (r_state == RD_ID) begin
            r_id_value <= readdata;
            r_id_ok    <= (readdata == EXPECTED_ID);
         end else begin
            r_ts_value <= readdata;
            r_ts_ok    <= (readdata == EXPECTED_TIMESTAMP);
         end
      end else if (w_expired) begin
         r_timeout  <= 1'b1;
      end
   end

   assign id_ok    = r_id_ok;
   assign ts_ok    = r_ts_ok;
   assign timeout  = r_timeout;
   assign id_value = r_id_value;
   assign ts_value = r_ts_value;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Randomized bench: a reactive slave with planned stall counts; expectations from a transaction-level model.
module tb_first_nios2_system_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd7;
   localparam logic [31:0] EXP_TS = 32'd1384977422;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  start, wr, rd, addr, busy, done, idok, tsok, tmo;
   logic [31:0] rdata [2];
   logic [31:0] idv   [2];
   logic [31:0] tsv   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   first_nios2_system_sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(255)
   ) dut0 (
      .clock(clk), .reset_n(rst_n), .start(start[0]), .address(addr[0]), .read(rd[0]),
      .waitrequest(wr[0]), .readdata(rdata[0]), .busy(busy[0]), .done(done[0]),
      .id_ok(idok[0]), .ts_ok(tsok[0]), .timeout(tmo[0]), .id_value(idv[0]), .ts_value(tsv[0])
   );

   first_nios2_system_sysid_checker #(
      .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(4)
   ) dut1 (
      .clock(clk), .reset_n(rst_n), .start(start[1]), .address(addr[1]), .read(rd[1]),
      .waitrequest(wr[1]), .readdata(rdata[1]), .busy(busy[1]), .done(done[1]),
      .id_ok(idok[1]), .ts_ok(tsok[1]), .timeout(tmo[1]), .id_value(idv[1]), .ts_value(tsv[1])
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // s0/s1: stall cycles the slave inserts before answering the ID / timestamp read
   task automatic run_seq(input int sel, input logic [31:0] idw, input logic [31:0] tsw,
                          input int s0, input int s1, input bit poke);
      int L, exp_done, cyc, rem, ph, bus_err;
      bit seen, to_id, exp_to;
      logic [31:0] hold_id;
      L        = (sel == 1) ? 4 : 255;
      to_id    = (s0 >= L);
      exp_to   = to_id || (s1 >= L);
      exp_done = to_id ? 1 + L : (s1 >= L) ? 2 + s0 + L : 3 + s0 + s1;

      start[sel] = 1'b1;
      @(posedge clk); #1;
      start[sel] = 1'b0;
      cyc = 1; ph = 0; rem = s0; seen = 0; bus_err = 0;
      while (cyc < 700) begin
         if (done[sel]) begin
            seen = 1;
            break;
         end
         start[sel] = poke && (ph == 1) && ($urandom_range(0, 1) == 1);
         if (busy[sel] !== 1'b1) bus_err++;
         if (rd[sel]) begin
            if (addr[sel] !== ph[0]) bus_err++;
            if (rem > 0) begin
               wr[sel] = 1'b1; rem--; rdata[sel] = $urandom;
            end else begin
               wr[sel] = 1'b0; rdata[sel] = (ph == 0) ? idw : tsw; ph++; rem = s1;
            end
         end else begin
            wr[sel] = 1'($urandom_range(0, 1)); rdata[sel] = $urandom;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_seen",  32'(seen), 32'd1);
      chk("done_cycle", 32'(cyc), 32'(exp_done));
      chk("bus_errs",   32'(bus_err), 32'd0);
      chk("id_ok",      32'(idok[sel]), 32'(!to_id && idw == EXP_ID));
      chk("ts_ok",      32'(tsok[sel]), 32'(!exp_to && tsw == EXP_TS));
      chk("timeout",    32'(tmo[sel]), 32'(exp_to));
      chk("id_value",   idv[sel], to_id ? 32'd0 : idw);
      chk("ts_value",   tsv[sel], exp_to ? 32'd0 : tsw);
      hold_id = idv[sel];
      // start coinciding with done must be dropped
      start[sel] = 1'b1;
      @(posedge clk); #1;
      start[sel] = 1'b0;
      wr[sel] = 1'b0;
      chk("done_width", 32'(done[sel]), 32'd0);
      chk("idle_after", 32'(busy[sel]), 32'd0);
      chk("hold_id",    idv[sel], hold_id);
   endtask

   initial begin
      start = '0; wr = '0; rdata[0] = '0; rdata[1] = '0;
      #12;
      for (int s = 0; s < 2; s++) begin
         chk("rst_read",  32'(rd[s]), 32'd0);
         chk("rst_busy",  32'(busy[s]), 32'd0);
         chk("rst_done",  32'(done[s]), 32'd0);
         chk("rst_flags", 32'({idok[s], tsok[s], tmo[s], addr[s]}), 32'd0);
         chk("rst_idv",   idv[s], 32'd0);
         chk("rst_tsv",   tsv[s], 32'd0);
      end
      rst_n = 1'b1;

      run_seq(0, EXP_ID, EXP_TS, 0, 0, 0);
      run_seq(0, 32'd8,  EXP_TS, 0, 0, 0);
      run_seq(0, EXP_ID, EXP_TS, 5, 5, 0);
      run_seq(1, EXP_ID, EXP_TS, 100000, 0, 0);
      run_seq(1, EXP_ID, EXP_TS, 1, 100000, 0);
      run_seq(1, EXP_ID, EXP_TS, 3, 3, 0);
      run_seq(0, EXP_ID, EXP_TS, 2, 1, 1);
      run_seq(0, EXP_ID, EXP_TS, 0, 0, 0);

      // reset while the timestamp read is stalled
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0; wr[0] = 1'b0; rdata[0] = EXP_ID;
      @(posedge clk); #1;
      wr[0] = 1'b1;
      chk("pre_rst_rdts", 32'({rd[0], addr[0]}), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_bus",   32'({rd[0], addr[0], busy[0], done[0]}), 32'd0);
      chk("mid_rst_flags", 32'({idok[0], tsok[0], tmo[0]}), 32'd0);
      chk("mid_rst_idv",   idv[0], 32'd0);
      @(posedge clk); #1;
      chk("mid_rst_nodone", 32'(done[0]), 32'd0);
      wr[0] = 1'b0;
      rst_n = 1'b1;
      run_seq(0, EXP_ID, EXP_TS, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         int sel, s0, s1;
         logic [31:0] idw, tsw;
         sel = n % 2;
         idw = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
         tsw = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
         if (sel == 1) begin
            s0 = $urandom_range(0, 6);
            s1 = $urandom_range(0, 6);
         end else begin
            s0 = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 6);
            s1 = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 6);
         end
         run_seq(sel, idw, tsw, s0, s1, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
